// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module : multicycle_control_if
// Brief  : Controller <-> datapath/memory signal bundle for multicycle_control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUOp;
    logic       instr_done;
    logic [3:0] state;

    // Controller side
    modport master (
        input  op, zero, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done, state
    );

    // Datapath / memory side
    modport slave (
        output op, zero, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done, state
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module : multicycle_control
// Brief  : Multicycle RISC-V style main controller FSM with memory handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    multicycle_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] c_OP_LW  = 7'b0000011;
    localparam logic [6:0] c_OP_SW  = 7'b0100011;
    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ = 7'b1100011;
    localparam logic [6:0] c_OP_JAL = 7'b1101111;

    state_t     r_state;
    state_t     w_next;
    logic       w_mem_req;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_reg_write;
    logic       w_mem_write;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_op;
    logic       w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_result_src = 2'b00;
        w_alu_op     = 2'b00;
        w_done       = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = bus.mem_ready;
                w_pc_update  = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (bus.op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_R:           w_next = S_EXECUTER;
                    c_OP_I:           w_next = S_EXECUTEI;
                    c_OP_JAL:         w_next = S_JAL;
                    c_OP_BEQ:         w_next = S_BEQ;
                    default:          w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = (bus.op == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_done       = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (bus.mem_ready) begin
                    w_done = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_EXECUTER: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_BEQ: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Write enables and the request are gated by rst_n so they drop the
    // instant reset asserts, without waiting for a clock edge.
    assign bus.mem_req    = w_mem_req   & rst_n;
    assign bus.IRWrite    = w_ir_write  & rst_n;
    assign bus.PCWrite    = (w_pc_update | (w_branch & bus.zero)) & rst_n;
    assign bus.RegWrite   = w_reg_write & rst_n;
    assign bus.MemWrite   = w_mem_write & rst_n;
    assign bus.instr_done = w_done      & rst_n;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUOp      = w_alu_op;
    assign bus.state      = r_state;

endmodule

`default_nettype wire
